// File: rtl/comparador_multi_if.sv
// comparador_multi_if: sample, threshold and level/edge bundle of the multi-channel comparator
interface comparador_multi_if #(
  parameter int N      = 8,
  parameter int CH     = 2,
  parameter int HOLD_W = 4
);
  logic              enable;
  logic              valid;
  logic [CH*N-1:0]   datain;
  logic [N-1:0]      thr_hi;
  logic [N-1:0]      thr_lo;
  logic [HOLD_W-1:0] hold;
  logic [CH-1:0]     clr_flag;
  logic [CH-1:0]     dataout;
  logic [CH-1:0]     rise;
  logic [CH-1:0]     fall;
  logic [CH-1:0]     flag;
  modport master (
    output enable, valid, datain, thr_hi, thr_lo, hold, clr_flag,
    input  dataout, rise, fall, flag
  );
  modport slave (
    input  enable, valid, datain, thr_hi, thr_lo, hold, clr_flag,
    output dataout, rise, fall, flag
  );
endinterface

// File: rtl/comparador_multi.sv
// comparador_multi: per-channel hysteresis comparator with debounce, edge pulses and sticky flag
module comparador_multi #(
  parameter int N      = 8,
  parameter int CH     = 2,
  parameter int HOLD_W = 4,
  parameter int SIGNED = 0
) (
  input logic clk,
  input logic rst,
  comparador_multi_if.slave bus
);
  // bit 1 of the encoding is the output level, so dataout comes straight off a flop
  typedef enum logic [1:0] {LOW = 2'b00, PEND_HI = 2'b01, HIGH = 2'b10, PEND_LO = 2'b11} state_t;
  state_t            state_q [CH];
  state_t            state_d [CH];
  logic [HOLD_W-1:0] cnt_q [CH];
  logic [HOLD_W-1:0] cnt_d [CH];
  logic [CH-1:0]     rise_q, rise_d, fall_q, fall_d, flag_q, flag_d, above, below;
  logic              acc;
  assign acc = bus.enable & bus.valid;
  for (genvar c = 0; c < CH; c++) begin : g_cmp
    logic [N-1:0] x;
    assign x        = bus.datain[c*N +: N];
    assign above[c] = (SIGNED != 0) ? ($signed(x) > $signed(bus.thr_hi)) : (x > bus.thr_hi);
    assign below[c] = (SIGNED != 0) ? ($signed(x) < $signed(bus.thr_lo)) : (x < bus.thr_lo);
    assign bus.dataout[c] = state_q[c][1];
  end
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
  assign bus.flag = flag_q;
  // next state, saturating run counter, edge pulses and sticky flag (set beats clear)
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      rise_d[c]  = 1'b0;
      fall_d[c]  = 1'b0;
      if (acc) begin
        case (state_q[c])
          LOW: if (above[c]) begin
            state_d[c] = (bus.hold == '0) ? HIGH : PEND_HI;
            cnt_d[c]   = (bus.hold == '0) ? '0 : HOLD_W'(1);
            rise_d[c]  = (bus.hold == '0);
          end
          PEND_HI: begin
            state_d[c] = !above[c] ? LOW : (cnt_q[c] >= bus.hold) ? HIGH : PEND_HI;
            cnt_d[c]   = (!above[c] || cnt_q[c] >= bus.hold) ? '0 : (&cnt_q[c]) ? cnt_q[c] : cnt_q[c] + 1'b1;
            rise_d[c]  = above[c] && (cnt_q[c] >= bus.hold);
          end
          HIGH: if (below[c]) begin
            state_d[c] = (bus.hold == '0) ? LOW : PEND_LO;
            cnt_d[c]   = (bus.hold == '0) ? '0 : HOLD_W'(1);
            fall_d[c]  = (bus.hold == '0);
          end
          default: begin
            state_d[c] = !below[c] ? HIGH : (cnt_q[c] >= bus.hold) ? LOW : PEND_LO;
            cnt_d[c]   = (!below[c] || cnt_q[c] >= bus.hold) ? '0 : (&cnt_q[c]) ? cnt_q[c] : cnt_q[c] + 1'b1;
            fall_d[c]  = below[c] && (cnt_q[c] >= bus.hold);
          end
        endcase
      end
    end
    flag_d = rise_d | (flag_q & ~({CH{bus.enable}} & bus.clr_flag));
  end
  // state registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        state_q[c] <= LOW;
        cnt_q[c]   <= '0;
      end
      rise_q <= '0;
      fall_q <= '0;
      flag_q <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      rise_q <= rise_d;
      fall_q <= fall_d;
      flag_q <= flag_d;
    end
  end
endmodule

// File: tb/tb_comparador_multi.sv
// tb_comparador_multi: scoreboard bench running an unsigned and a signed instance side by side
module tb_comparador_multi;
  localparam int N = 8, CH = 2, HW = 4;
  typedef struct packed {logic [CH-1:0] d, r, f, fl;} obs_t;
  logic clk = 1'b0, rst = 1'b0;
  logic en = 1'b0, vld = 1'b0;
  logic [CH*N-1:0] din = '0;
  logic [N-1:0] thr_hi = 8'd5, thr_lo = 8'd2;
  logic [HW-1:0] hold = '0;
  logic [CH-1:0] clr_f = '0;
  int checks = 0, failures = 0;
  obs_t qu[$], qs[$];
  obs_t eu_m, es_m;
  bit lvl [2][CH];
  int run [2][CH];
  bit flg [2][CH];
  comparador_multi_if #(.N(N), .CH(CH), .HOLD_W(HW)) bu ();
  comparador_multi_if #(.N(N), .CH(CH), .HOLD_W(HW)) bs ();
  assign bu.enable = en;   assign bs.enable = en;
  assign bu.valid = vld;   assign bs.valid = vld;
  assign bu.datain = din;  assign bs.datain = din;
  assign bu.thr_hi = thr_hi; assign bs.thr_hi = thr_hi;
  assign bu.thr_lo = thr_lo; assign bs.thr_lo = thr_lo;
  assign bu.hold = hold;   assign bs.hold = hold;
  assign bu.clr_flag = clr_f; assign bs.clr_flag = clr_f;
  comparador_multi #(.N(N), .CH(CH), .HOLD_W(HW), .SIGNED(0)) u_dut_u (.clk(clk), .rst(rst), .bus(bu));
  comparador_multi #(.N(N), .CH(CH), .HOLD_W(HW), .SIGNED(1)) u_dut_s (.clk(clk), .rst(rst), .bus(bs));
  always #5 clk = ~clk;
  task automatic cmp(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (qu.size() > 0 && qs.size() > 0) begin
      eu_m = qu.pop_front();
      es_m = qs.pop_front();
      cmp("u_dataout", bu.dataout, eu_m.d);
      cmp("u_rise", bu.rise, eu_m.r);
      cmp("u_fall", bu.fall, eu_m.f);
      cmp("u_flag", bu.flag, eu_m.fl);
      cmp("s_dataout", bs.dataout, es_m.d);
      cmp("s_rise", bs.rise, es_m.r);
      cmp("s_fall", bs.fall, es_m.f);
      cmp("s_flag", bs.flag, es_m.fl);
    end
  end
  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < CH; c++) begin
        lvl[m][c] = 0;
        run[m][c] = 0;
        flg[m][c] = 0;
      end
  endtask
  // a level flips after hold+1 consecutive accepted samples on the far side of its threshold
  task automatic step(input bit e, input bit v, input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] clr);
    obs_t ex [2];
    en = e; vld = v; din = {d1, d0}; clr_f = clr;
    for (int m = 0; m < 2; m++) begin
      ex[m] = '0;
      for (int c = 0; c < CH; c++) begin
        logic [7:0] x;
        int xi, hi, lo;
        bit q;
        x = (c == 0) ? d0 : d1;
        xi = m ? int'($signed(x)) : int'(x);
        hi = m ? int'($signed(thr_hi)) : int'(thr_hi);
        lo = m ? int'($signed(thr_lo)) : int'(thr_lo);
        if (e && v) begin
          q = lvl[m][c] ? (xi < lo) : (xi > hi);
          if (!q) run[m][c] = 0;
          else if (run[m][c] >= int'(hold)) begin
            lvl[m][c] = !lvl[m][c];
            run[m][c] = 0;
            if (lvl[m][c]) ex[m].r[c] = 1'b1; else ex[m].f[c] = 1'b1;
          end else run[m][c]++;
        end
        flg[m][c] = ex[m].r[c] || (flg[m][c] && !(e && clr[c]));
        ex[m].d[c] = lvl[m][c];
        ex[m].fl[c] = flg[m][c];
      end
    end
    @(posedge clk);
    #1;
    qu.push_back(ex[0]);
    qs.push_back(ex[1]);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    cmp("rst_u_dataout", bu.dataout, '0);
    cmp("rst_u_rise", bu.rise, '0);
    cmp("rst_u_flag", bu.flag, '0);
    cmp("rst_s_dataout", bs.dataout, '0);
    cmp("rst_s_flag", bs.flag, '0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b1;
  endtask
  initial begin
    model_reset();
    #3;
    cmp("init_dataout", bu.dataout, '0);
    cmp("init_flag", bu.flag, '0);
    @(posedge clk);
    #2 rst = 1'b1;
    thr_hi = 8'd5; thr_lo = 8'd2; hold = 0;
    foreach (din[i]) ;
    step(1, 1, 10, 0, 0); step(1, 1, 10, 0, 0); step(1, 1, 10, 0, 0); step(1, 1, 0, 0, 0);
    step(1, 1, 10, 0, 0); step(1, 1, 4, 0, 0); step(1, 1, 3, 0, 0); step(1, 1, 2, 0, 0); step(1, 1, 1, 0, 0);
    hold = 2;
    step(1, 1, 10, 0, 0); step(1, 1, 10, 0, 0); step(1, 1, 0, 0, 0);
    step(1, 1, 10, 0, 0); step(1, 1, 10, 0, 0); step(1, 1, 10, 0, 0);
    hold = 0; step(1, 1, 0, 0, 0);
    hold = 2;
    step(1, 1, 10, 0, 0); step(1, 1, 10, 0, 0); step(1, 1, 0, 0, 0);
    step(1, 1, 10, 0, 0); step(1, 0, 0, 0, 0); step(1, 1, 10, 0, 0);
    step(0, 1, 0, 0, 0); step(1, 1, 10, 0, 0); step(1, 1, 10, 0, 0);
    hold = 0; step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
    thr_hi = 8'hFD; thr_lo = 8'hF6;
    step(1, 1, 8'h00, 0, 0); step(1, 1, 8'hF8, 0, 0); step(1, 1, 8'h80, 0, 0);
    thr_hi = 8'd5; thr_lo = 8'd2;
    step(1, 1, 8'h80, 0, 0); step(1, 1, 0, 0, 0);
    step(1, 1, 10, 0, 2'b01); step(1, 1, 10, 0, 2'b01); step(1, 1, 0, 0, 0);
    hold = 4'hF;
    for (int i = 0; i < 20; i++) step(1, 1, 200, 200, 0);
    hold = 0;
    step(1, 1, 10, 0, 0);
    do_reset();
    step(1, 1, 3, 0, 0); step(1, 1, 3, 0, 0);
    hold = 3;
    step(1, 1, 10, 0, 0); step(1, 1, 10, 0, 0);
    do_reset();
    step(1, 1, 10, 0, 0); step(1, 1, 10, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        thr_hi = 8'($urandom);
        thr_lo = (i % 200 == 0) ? 8'($urandom) : 8'(thr_hi - 8'($urandom_range(0, 60)));
      end
      if (i % 37 == 0) hold = 4'($urandom_range(0, 3));
      if (i % 211 == 0) hold = 4'hF;
      if (i % 400 == 399) do_reset();
      step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
           ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00);
    end
    repeat (2) @(posedge clk);
    checks++;
    if (qu.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d expected=0", qu.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
